pipe_hazard_trap_ctrl: RTL and testbench
========================================

Name: pipe_hazard_trap_ctrl

Overview:
Central pipeline sequencer for the 5-stage MIPS core. It drives stall, bubble and flush controls into the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and computes the RAW data-hazard stall from Tuse/Tnew. It times the multi-cycle MULT/DIV unit with a busy counter. It also sequences interrupt, exception and ERET entry: whole-pipeline flush, EPC capture with branch-delay correction, and PC redirect.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu start
DIV_CYCLES, 10, busy cycles after a div/divu start
EXC_VECTOR, 32'h0000_4180, handler entry PC

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low (reset==0 clears all state on posedge clk)
rs_D, rt_D  in  5 each  source register numbers in D
rs_used_D, rt_used_D  in  1 each  D instruction reads rs/rt
tuse_rs_D, tuse_rt_D  in  2 each  cycles until operand needed
waddr_E, waddr_M  in  5 each  destination register in E/M
tnew_E, tnew_M  in  2 each  cycles until result available
md_use_D  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
md_start_E  in  1  mult/div in E requests start
md_div_E  in  1  1=div type, 0=mult type
exc_req_M  in  1  exception detected in M
int_req  in  1  CP0 interrupt pending and enabled (level)
eret_M  in  1  eret in M
pc_M  in  32  PC of M instruction
bd_M  in  1  M instruction is in a delay slot
epc_q  in  32  current CP0 EPC
stall_FD  out  1  hold PC and IF/ID
bubble_E  out  1  clear ID/EX
flush_all  out  1  clear IF/ID, ID/EX, EX/MEM, MEM/WB
md_start_ok  out  1  qualified MDU start
md_busy  out  1  MDU counter nonzero
pc_redirect  out  1  next PC = redirect_pc
redirect_pc  out  32  EXC_VECTOR or epc_q
epc_we  out  1  write EPC and set EXL
epc_wdata  out  32  EPC value

Behaviour:
- Reset: state=RUN, md_cnt=0. All outputs 0, except redirect_pc, which equals EXC_VECTOR.
- Hazard term per source src in {rs,rt}: src_used && src!=0 && ((src==waddr_E && tuse<tnew_E) || (src==waddr_M && tuse<tnew_M)).
- MD hazard: md_use_D && (md_busy || md_start_E).
- stall = hazard_rs | hazard_rt | md_hazard. When set and no trap: stall_FD=1, bubble_E=1. All of this is combinational.
- trap_now = state==RUN && (exc_req_M || int_req). Priority: exc_req_M > int_req > eret_M.
- trap_now is combinational in the same cycle:
  - flush_all=1, pc_redirect=1, redirect_pc=EXC_VECTOR, epc_we=1.
  - epc_wdata = bd_M ? pc_M-4 : pc_M, with bits [1:0] forced to 00.
  - stall_FD and bubble_E are forced to 0.
- eret (eret_M && !trap_now && state==RUN) is combinational: flush_all=1, pc_redirect=1, redirect_pc=epc_q, epc_we=0.
- FSM: RUN goes to TRAP on trap_now, and to RET on eret. TRAP and RET return to RUN after exactly 1 cycle. In TRAP and RET, int_req, exc_req_M and eret_M are ignored, which lets CP0 EXL propagate. stall is still evaluated there.
- md_start_ok = md_start_E && !trap_now && !md_busy.
- On md_start_ok, md_cnt loads DIV_CYCLES or MULT_CYCLES. Otherwise md_cnt decrements while nonzero and saturates at 0. A running count continues through a trap.
- md_busy = (md_cnt!=0).
- Mid-operation reset (reset==0) aborts a running count and returns the FSM to RUN on that posedge.

Optional Feature:
PIPE_PERF_CNT_EN:
- Defined: adds output ports stall_cnt[31:0] and trap_cnt[31:0]. stall_cnt increments each cycle stall_FD=1; trap_cnt increments on each trap_now. Both are cleared by reset and wrap at 2^32.
- Not defined: the ports and counters are absent and all other behaviour is identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds: FSM state encoding (RUN, TRAP, RET), EXC_VECTOR default, MULT_CYCLES/DIV_CYCLES defaults, and the 2-bit Tnew/Tuse type.
- One natural sub-module, md_busy_timer: the counter, load select and md_busy output.

Test Plan:
- RAW stall: lw $1 in E (tnew_E=2), D reads $1 with tuse=0 → stall_FD=1, bubble_E=1. The following cycle has tnew_M=1 → still stalled. Then released.
- $0 guard: waddr_E=0, rs_D=0, tnew_E=2 → stall_FD=0.
- MDU: div start (md_start_E=1, md_div_E=1) → md_busy high for 10 cycles. An mflo in D stalls all 10 cycles and issues in cycle 11. A second start while busy gives md_start_ok=0.
- Delay-slot interrupt: int_req=1, pc_M=0x3008, bd_M=1 → same cycle: epc_wdata=0x3004, flush_all=1, redirect_pc=0x4180. The next cycle (TRAP) ignores int_req.
- Simultaneous exc_req_M, eret_M and md_start_E → trap is taken, md_start_ok=0, redirect_pc=0x4180.
- ERET: eret_M=1, epc_q=0x3010 → redirect_pc=0x3010, epc_we=0. reset=0 during TRAP → state returns to RUN and all outputs clear.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM states, default
// timing parameters, the Tnew/Tuse type and the RAW hazard helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_RET  = 2'd2
  } ctrl_state_e;

  typedef logic [1:0] tstage_t;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam logic [31:0] EXC_VECTOR_DEF  = 32'h0000_4180;

  // One source operand conflicts with a producer in E or M that cannot
  // deliver its result before the consumer needs it. $0 never conflicts.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic       used,
    input tstage_t    tuse,
    input logic [4:0] waddr_e,
    input tstage_t    tnew_e,
    input logic [4:0] waddr_m,
    input tstage_t    tnew_m
  );
    return used && (src != 5'd0) &&
           (((src == waddr_e) && (tuse < tnew_e)) ||
            ((src == waddr_m) && (tuse < tnew_m)));
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide busy timer: loads the operation latency on a qualified
// start and counts down to zero; busy while the count is nonzero.
module md_busy_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic busy
);

  localparam int unsigned MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CW   = ($clog2(MAXC + 1) < 1) ? 1 : $clog2(MAXC + 1);

  logic [CW-1:0] cnt_d, cnt_q;

  // Next count: load latency on start, else saturating decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register; reset aborts any running operation.
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_trap_ctrl.sv
// Pipeline sequencer: RAW/MDU stall, trap/ERET flush and redirect, EPC
// capture. Optional PIPE_PERF_CNT_EN adds stall_cnt/trap_cnt counters.
module pipe_hazard_trap_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic        rs_used_D,
  input  logic        rt_used_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic [4:0]  waddr_E,
  input  logic [4:0]  waddr_M,
  input  logic [1:0]  tnew_E,
  input  logic [1:0]  tnew_M,
  input  logic        md_use_D,
  input  logic        md_start_E,
  input  logic        md_div_E,
  input  logic        exc_req_M,
  input  logic        int_req,
  input  logic        eret_M,
  input  logic [31:0] pc_M,
  input  logic        bd_M,
  input  logic [31:0] epc_q,
  output logic        stall_FD,
  output logic        bubble_E,
  output logic        flush_all,
  output logic        md_start_ok,
  output logic        md_busy,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        epc_we,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] trap_cnt,
`endif
  output logic [31:0] epc_wdata
);

  ctrl_state_e state_d, state_q;
  logic        stall;
  logic        trap_now;
  logic        eret_now;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_timer (
    .clk   (clk),
    .reset (reset),
    .start (md_start_ok),
    .div   (md_div_E),
    .busy  (md_busy)
  );

  // Hazard detection, trap/ERET decode, FSM next state and all controls.
  always_comb begin
    stall = src_hazard(rs_D, rs_used_D, tuse_rs_D, waddr_E, tnew_E, waddr_M, tnew_M) |
            src_hazard(rt_D, rt_used_D, tuse_rt_D, waddr_E, tnew_E, waddr_M, tnew_M) |
            (md_use_D && (md_busy || md_start_E));

    trap_now = (state_q == ST_RUN) && (exc_req_M || int_req);
    eret_now = (state_q == ST_RUN) && eret_M && !trap_now;

    state_d     = ST_RUN;
    stall_FD    = 1'b0;
    bubble_E    = 1'b0;
    flush_all   = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = EXC_VECTOR;
    epc_we      = 1'b0;
    epc_wdata   = '0;
    md_start_ok = md_start_E && !trap_now && !md_busy;

    if (trap_now) begin
      state_d     = ST_TRAP;
      flush_all   = 1'b1;
      pc_redirect = 1'b1;
      epc_we      = 1'b1;
      epc_wdata   = (bd_M ? (pc_M - 32'd4) : pc_M) & 32'hFFFF_FFFC;
    end else if (eret_now) begin
      state_d     = ST_RET;
      flush_all   = 1'b1;
      pc_redirect = 1'b1;
      redirect_pc = epc_q;
    end else begin
      stall_FD = stall;
      bubble_E = stall;
    end
  end

  // FSM state register; TRAP/RET always fall back to RUN next cycle.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] trap_cnt_d, trap_cnt_q;

  // Event counters, wrapping naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall_FD};
    trap_cnt_d  = trap_cnt_q + {31'd0, trap_now};
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      trap_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      trap_cnt_q  <= trap_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign trap_cnt  = trap_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_trap_ctrl.sv
// Self-checking bench for pipe_hazard_trap_ctrl: vector table, directed
// multi-cycle sequences and randomized stimulus against a reference model.
module tb_pipe_hazard_trap_ctrl;

  localparam int MULT_C = 5;
  localparam int DIV_C  = 10;
  localparam logic [31:0] VEC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, waddr_E, waddr_M;
  logic        rs_used_D, rt_used_D;
  logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic        md_use_D, md_start_E, md_div_E;
  logic        exc_req_M, int_req, eret_M, bd_M;
  logic [31:0] pc_M, epc_q;
  logic        stall_FD, bubble_E, flush_all, md_start_ok, md_busy;
  logic        pc_redirect, epc_we;
  logic [31:0] redirect_pc, epc_wdata;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, trap_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state: "in window" means the cycle after a trap/eret.
  bit m_win;
  int m_rem;

  always #5 clk = ~clk;

  pipe_hazard_trap_ctrl dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .rs_used_D(rs_used_D), .rt_used_D(rt_used_D),
    .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .waddr_E(waddr_E), .waddr_M(waddr_M), .tnew_E(tnew_E), .tnew_M(tnew_M),
    .md_use_D(md_use_D), .md_start_E(md_start_E), .md_div_E(md_div_E),
    .exc_req_M(exc_req_M), .int_req(int_req), .eret_M(eret_M),
    .pc_M(pc_M), .bd_M(bd_M), .epc_q(epc_q),
    .stall_FD(stall_FD), .bubble_E(bubble_E), .flush_all(flush_all),
    .md_start_ok(md_start_ok), .md_busy(md_busy),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .epc_we(epc_we),
`ifdef PIPE_PERF_CNT_EN
    .stall_cnt(stall_cnt), .trap_cnt(trap_cnt),
`endif
    .epc_wdata(epc_wdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b1;
    rs_D = '0; rt_D = '0; rs_used_D = 0; rt_used_D = 0;
    tuse_rs_D = '0; tuse_rt_D = '0; waddr_E = '0; waddr_M = '0;
    tnew_E = '0; tnew_M = '0; md_use_D = 0; md_start_E = 0; md_div_E = 0;
    exc_req_M = 0; int_req = 0; eret_M = 0; pc_M = '0; bd_M = 0; epc_q = '0;
  endtask

  function automatic bit op_haz(input int src, input bit used, input int tuse);
    if (!used || src == 0) return 0;
    if (src == int'(waddr_E) && tuse < int'(tnew_E)) return 1;
    if (src == int'(waddr_M) && tuse < int'(tnew_M)) return 1;
    return 0;
  endfunction

  // Compare every output against what the rules predict from the current
  // inputs and model state.
  task automatic model_check();
    bit st, trap, er, ok;
    logic [31:0] ew, rp;
    st = op_haz(rs_D, rs_used_D, tuse_rs_D) || op_haz(rt_D, rt_used_D, tuse_rt_D) ||
         (md_use_D && (m_rem > 0 || md_start_E));
    trap = !m_win && (exc_req_M || int_req);
    er   = !m_win && eret_M && !trap;
    ok   = md_start_E && !trap && m_rem == 0;
    ew   = trap ? ((bd_M ? pc_M - 4 : pc_M) / 4 * 4) : 32'd0;
    rp   = er ? epc_q : VEC;
    chk("rnd_stall_FD", {31'd0, stall_FD}, {31'd0, st && !trap && !er});
    chk("rnd_bubble_E", {31'd0, bubble_E}, {31'd0, st && !trap && !er});
    chk("rnd_flush_all", {31'd0, flush_all}, {31'd0, trap || er});
    chk("rnd_pc_redirect", {31'd0, pc_redirect}, {31'd0, trap || er});
    chk("rnd_redirect_pc", redirect_pc, rp);
    chk("rnd_epc_we", {31'd0, epc_we}, {31'd0, trap});
    chk("rnd_epc_wdata", epc_wdata, ew);
    chk("rnd_md_start_ok", {31'd0, md_start_ok}, {31'd0, ok});
    chk("rnd_md_busy", {31'd0, md_busy}, {31'd0, m_rem > 0});
  endtask

  // Advance the model over the coming clock edge, then wait for the next
  // negative edge where new inputs are applied.
  task automatic adv();
    bit trap, er, ok;
    if (!reset) begin
      m_win = 0;
      m_rem = 0;
    end else begin
      trap = !m_win && (exc_req_M || int_req);
      er   = !m_win && eret_M && !trap;
      ok   = md_start_E && !trap && m_rem == 0;
      m_win = trap || er;
      if (ok) m_rem = md_div_E ? DIV_C : MULT_C;
      else if (m_rem > 0) m_rem--;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [4:0] rs, rt;
    logic       rsu, rtu;
    logic [1:0] tur, tut;
    logic [4:0] we, wm;
    logic [1:0] tne, tnm;
    logic       exp_stall;
  } vec_t;

  vec_t vt[9];

  initial begin
    vt[0] = '{5'd1, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd1, 5'd0, 2'd2, 2'd0, 1'b1};
    vt[1] = '{5'd1, 5'd0, 1'b1, 1'b0, 2'd2, 2'd0, 5'd1, 5'd0, 2'd2, 2'd0, 1'b0};
    vt[2] = '{5'd1, 5'd0, 1'b1, 1'b0, 2'd1, 2'd0, 5'd1, 5'd0, 2'd2, 2'd0, 1'b1};
    vt[3] = '{5'd0, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd0, 5'd0, 2'd2, 2'd0, 1'b0};
    vt[4] = '{5'd0, 5'd3, 1'b0, 1'b1, 2'd0, 2'd0, 5'd0, 5'd3, 2'd0, 2'd1, 1'b1};
    vt[5] = '{5'd0, 5'd3, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 5'd3, 2'd0, 2'd1, 1'b0};
    vt[6] = '{5'd0, 5'd3, 1'b0, 1'b1, 2'd0, 2'd1, 5'd0, 5'd3, 2'd0, 2'd1, 1'b0};
    vt[7] = '{5'd2, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd5, 5'd2, 2'd3, 2'd0, 1'b0};
    vt[8] = '{5'd4, 5'd4, 1'b1, 1'b1, 2'd1, 2'd1, 5'd4, 5'd4, 2'd1, 2'd2, 1'b1};

    idle();
    m_win = 0; m_rem = 0;
    reset = 1'b0;
    adv(); adv();
    reset = 1'b1;

    // Reset state
    #1;
    chk("rst_stall_FD", {31'd0, stall_FD}, 32'd0);
    chk("rst_bubble_E", {31'd0, bubble_E}, 32'd0);
    chk("rst_flush_all", {31'd0, flush_all}, 32'd0);
    chk("rst_md_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_md_start_ok", {31'd0, md_start_ok}, 32'd0);
    chk("rst_pc_redirect", {31'd0, pc_redirect}, 32'd0);
    chk("rst_epc_we", {31'd0, epc_we}, 32'd0);
    chk("rst_epc_wdata", epc_wdata, 32'd0);
    chk("rst_redirect_pc", redirect_pc, VEC);
    adv();

    // Hazard vector table
    for (int i = 0; i < 9; i++) begin
      idle();
      rs_D = vt[i].rs; rt_D = vt[i].rt; rs_used_D = vt[i].rsu; rt_used_D = vt[i].rtu;
      tuse_rs_D = vt[i].tur; tuse_rt_D = vt[i].tut; waddr_E = vt[i].we; waddr_M = vt[i].wm;
      tnew_E = vt[i].tne; tnew_M = vt[i].tnm;
      #1;
      chk($sformatf("vec%0d_stall_FD", i), {31'd0, stall_FD}, {31'd0, vt[i].exp_stall});
      chk($sformatf("vec%0d_bubble_E", i), {31'd0, bubble_E}, {31'd0, vt[i].exp_stall});
      chk($sformatf("vec%0d_flush", i), {31'd0, flush_all}, 32'd0);
      adv();
    end

    // RAW load-use: stall in E, still stalled from M, then released
    idle(); rs_D = 5'd1; rs_used_D = 1; waddr_E = 5'd1; tnew_E = 2'd2; #1;
    chk("raw_c1_stall", {31'd0, stall_FD}, 32'd1);
    chk("raw_c1_bubble", {31'd0, bubble_E}, 32'd1);
    adv();
    waddr_E = 5'd0; tnew_E = 2'd0; waddr_M = 5'd1; tnew_M = 2'd1; #1;
    chk("raw_c2_stall", {31'd0, stall_FD}, 32'd1);
    adv();
    waddr_M = 5'd0; tnew_M = 2'd0; #1;
    chk("raw_c3_stall", {31'd0, stall_FD}, 32'd0);
    adv();

    // Divide: busy 10 cycles, mflo stalls throughout, restart refused
    idle(); md_use_D = 1; md_start_E = 1; md_div_E = 1; #1;
    chk("div_start_ok", {31'd0, md_start_ok}, 32'd1);
    chk("div_start_stall", {31'd0, stall_FD}, 32'd1);
    adv();
    for (int i = 1; i <= 10; i++) begin
      md_start_E = (i == 3); #1;
      chk($sformatf("div_busy_c%0d", i), {31'd0, md_busy}, 32'd1);
      chk($sformatf("div_stall_c%0d", i), {31'd0, stall_FD}, 32'd1);
      if (i == 3) chk("div_restart_ok", {31'd0, md_start_ok}, 32'd0);
      adv();
    end
    md_start_E = 0; #1;
    chk("div_c11_busy", {31'd0, md_busy}, 32'd0);
    chk("div_c11_stall", {31'd0, stall_FD}, 32'd0);
    adv();

    // Delay-slot interrupt, then TRAP cycle ignores the level
    idle(); int_req = 1; pc_M = 32'h3008; bd_M = 1; rs_D = 5'd1; rs_used_D = 1;
    waddr_E = 5'd1; tnew_E = 2'd2; #1;
    chk("int_epc_wdata", epc_wdata, 32'h3004);
    chk("int_flush", {31'd0, flush_all}, 32'd1);
    chk("int_redirect_pc", redirect_pc, VEC);
    chk("int_epc_we", {31'd0, epc_we}, 32'd1);
    chk("int_stall_forced0", {31'd0, stall_FD}, 32'd0);
    adv();
    #1;
    chk("int_trap_flush", {31'd0, flush_all}, 32'd0);
    chk("int_trap_epc_we", {31'd0, epc_we}, 32'd0);
    chk("int_trap_stall", {31'd0, stall_FD}, 32'd1);
    adv();
    idle(); adv();

    // Exception beats eret and MDU start
    idle(); exc_req_M = 1; eret_M = 1; md_start_E = 1; epc_q = 32'h5550; pc_M = 32'h3003; #1;
    chk("exc_md_start_ok", {31'd0, md_start_ok}, 32'd0);
    chk("exc_redirect_pc", redirect_pc, VEC);
    chk("exc_epc_wdata", epc_wdata, 32'h3000);
    chk("exc_md_busy", {31'd0, md_busy}, 32'd0);
    adv();
    idle(); adv();

    // ERET
    idle(); eret_M = 1; epc_q = 32'h3010; #1;
    chk("eret_redirect_pc", redirect_pc, 32'h3010);
    chk("eret_epc_we", {31'd0, epc_we}, 32'd0);
    chk("eret_pc_redirect", {31'd0, pc_redirect}, 32'd1);
    chk("eret_flush", {31'd0, flush_all}, 32'd1);
    adv();
    #1;
    chk("eret_ret_flush", {31'd0, flush_all}, 32'd0);
    adv();

    // Reset during TRAP aborts a running multiply
    idle(); md_start_E = 1; #1;
    chk("rt_mult_ok", {31'd0, md_start_ok}, 32'd1);
    adv();
    idle(); exc_req_M = 1; pc_M = 32'h2000; #1;
    chk("rt_trap_flush", {31'd0, flush_all}, 32'd1);
    chk("rt_trap_busy", {31'd0, md_busy}, 32'd1);
    adv();
    idle(); reset = 0; adv();
    idle(); #1;
    chk("rt_after_busy", {31'd0, md_busy}, 32'd0);
    chk("rt_after_flush", {31'd0, flush_all}, 32'd0);
    chk("rt_after_redirect", {31'd0, pc_redirect}, 32'd0);
    chk("rt_after_redirect_pc", redirect_pc, VEC);
    adv();
    int_req = 1; #1;
    chk("rt_run_trap", {31'd0, flush_all}, 32'd1);
    adv();
    idle(); adv();

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 39) != 0);
      rs_D      = 5'($urandom_range(0, 3));
      rt_D      = 5'($urandom_range(0, 3));
      rs_used_D = 1'($urandom_range(0, 1));
      rt_used_D = 1'($urandom_range(0, 1));
      tuse_rs_D = 2'($urandom_range(0, 3));
      tuse_rt_D = 2'($urandom_range(0, 3));
      waddr_E   = 5'($urandom_range(0, 3));
      waddr_M   = 5'($urandom_range(0, 3));
      tnew_E    = 2'($urandom_range(0, 3));
      tnew_M    = 2'($urandom_range(0, 3));
      md_use_D  = ($urandom_range(0, 3) == 0);
      md_start_E = ($urandom_range(0, 5) == 0);
      md_div_E  = 1'($urandom_range(0, 1));
      exc_req_M = ($urandom_range(0, 9) == 0);
      int_req   = ($urandom_range(0, 9) == 0);
      eret_M    = ($urandom_range(0, 7) == 0);
      bd_M      = 1'($urandom_range(0, 1));
      pc_M      = $urandom;
      epc_q     = $urandom;
      #1;
      if (reset) model_check();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
